// File: rtl/emesh_dispatch_pkg.sv
// Shared definitions for the emesh dispatcher: packet field offsets, the
// destination select-field extractor and a constant clog2 helper.
package emesh_dispatch_pkg;

  localparam int unsigned DSTADDR_LSB = 8;
  localparam int unsigned MAX_PW      = 1024;
  localparam int unsigned MAX_SELW    = 32;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Top selw bits of the aw-bit dstaddr field, zero-extended to MAX_SELW.
  function automatic logic [MAX_SELW-1:0] sel_field(input logic [MAX_PW-1:0] pkt,
                                                    input int unsigned aw,
                                                    input int unsigned selw);
    logic [MAX_PW-1:0] sh;
    sh = pkt >> (DSTADDR_LSB + aw - selw);
    sel_field = '0;
    for (int unsigned i = 0; i < MAX_SELW; i++) begin
      if (i < selw) sel_field[i] = sh[i];
    end
  endfunction

endpackage

// File: rtl/emesh_dispatch_fifo.sv
// Show-ahead synchronous FIFO with extended pointers; a full FIFO accepts a
// push in the same cycle as a pop.
module emesh_dispatch_fifo
  import emesh_dispatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = 104
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          push,
  input  logic          pop,
  input  logic [PW-1:0] din,
  output logic [PW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          pop_full
);

  localparam int unsigned IW   = clog2(DEPTH);
  localparam int unsigned PTRW = IW + 1;

  logic [PW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTRW-1] != rd_ptr[PTRW-1]) &&
                    (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_full = full & do_pop;
  assign dout     = mem[rd_ptr[IW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTRW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTRW'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and reset-free memory maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IW-1:0]] <= din;
  end

endmodule

// File: rtl/emesh_dispatch.sv
// N-way emesh address router: decodes the dstaddr select field, steers each
// packet into a per-channel FIFO and drops/counts unmapped packets.
module emesh_dispatch
  import emesh_dispatch_pkg::*;
#(
  parameter int N     = 4,
  parameter int AW    = 32,
  parameter int PW    = 104,
  parameter int SELW  = 12,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    chan_en,
  input  logic            access_in,
  input  logic [PW-1:0]   packet_in,
  output logic            wait_out,
  output logic [N-1:0]    access_out,
  output logic [N*PW-1:0] packet_out,
  input  logic [N-1:0]    wait_in,
  output logic [CW-1:0]   drop_count,
  output logic            drop_pulse
);

  localparam int unsigned IW  = clog2(N);
  localparam int unsigned NP2 = 2 ** IW;

  logic [MAX_PW-1:0]   pkt_ext;
  logic [MAX_SELW-1:0] sel;
  logic [IW-1:0]       target;
  logic [NP2-1:0]      chan_en_ext;
  logic [NP2-1:0]      blocked;
  logic [N-1:0]        full;
  logic [N-1:0]        empty;
  logic [N-1:0]        pop_full;
  logic [N-1:0]        push;
  logic [N-1:0]        pop;
  logic                mapped;
  logic                accept;
  logic                drop;

  assign pkt_ext     = MAX_PW'(packet_in);
  assign sel         = sel_field(pkt_ext, AW, SELW);
  assign target      = sel[IW-1:0];
  // Padded to a power of two so a decoded index beyond N-1 never reads past the vector.
  assign chan_en_ext = NP2'(chan_en);
  assign mapped      = (sel < MAX_SELW'(N)) & chan_en_ext[target];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    blocked = '0;
    for (int k = 0; k < N; k++) blocked[k] = full[k] & ~pop_full[k];
  end

  assign wait_out = access_in & mapped & blocked[target];
  assign accept   = access_in & ~wait_out;
  assign drop     = accept & ~mapped;

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign pop[k]        = ~empty[k] & ~wait_in[k];
    assign push[k]       = accept & mapped & (target == IW'(k));
    assign access_out[k] = ~empty[k];

    emesh_dispatch_fifo #(
      .DEPTH (DEPTH),
      .PW    (PW)
    ) u_fifo (
      .clk      (clk),
      .nreset   (nreset),
      .push     (push[k]),
      .pop      (pop[k]),
      .din      (packet_in),
      .dout     (packet_out[k*PW +: PW]),
      .full     (full[k]),
      .empty    (empty[k]),
      .pop_full (pop_full[k])
    );
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      drop_count <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (drop && (drop_count != '1)) drop_count <= drop_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_emesh_dispatch.sv
// Directed self-checking bench for emesh_dispatch (N=4, DEPTH=4, CW=4).
module tb_emesh_dispatch;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int PW    = 104;
  localparam int SELW  = 12;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic            clk;
  logic            nreset;
  logic [N-1:0]    chan_en;
  logic            access_in;
  logic [PW-1:0]   packet_in;
  logic            wait_out;
  logic [N-1:0]    access_out;
  logic [N*PW-1:0] packet_out;
  logic [N-1:0]    wait_in;
  logic [CW-1:0]   drop_count;
  logic            drop_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  emesh_dispatch #(
    .N(N), .AW(AW), .PW(PW), .SELW(SELW), .DEPTH(DEPTH), .CW(CW)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .chan_en    (chan_en),
    .access_in  (access_in),
    .packet_in  (packet_in),
    .wait_out   (wait_out),
    .access_out (access_out),
    .packet_out (packet_out),
    .wait_in    (wait_in),
    .drop_count (drop_count),
    .drop_pulse (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] make_pkt(input int sel, input logic [31:0] tag);
    logic [PW-1:0] p;
    p          = '0;
    p[39:28]   = sel[11:0];
    p[27:8]    = tag[19:0];
    p[7:0]     = tag[7:0];
    p[103:72]  = tag;
    return p;
  endfunction

  function automatic logic [PW-1:0] chan_pkt(input int k);
    return packet_out[k*PW +: PW];
  endfunction

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic [31:0] tag);
    access_in = 1'b1;
    packet_in = make_pkt(sel, tag);
    #1;
  endtask

  initial begin
    nreset    = 1'b0;
    chan_en   = 4'hF;
    access_in = 1'b0;
    packet_in = '0;
    wait_in   = '0;
    #12;
    check("rst_access_out", PW'(access_out), PW'(4'b0000));
    check("rst_drop_count", PW'(drop_count), PW'(4'd0));
    check("rst_drop_pulse", PW'(drop_pulse), PW'(1'b0));
    check("rst_wait_out",   PW'(wait_out),   PW'(1'b0));
    #5 nreset = 1'b1;
    tick();

    // One packet to each channel: visible one cycle after acceptance.
    for (int i = 0; i < N; i++) begin
      drive(i, 32'hA0 + i);
      check($sformatf("t1_wait_%0d", i), PW'(wait_out), PW'(1'b0));
      tick();
      access_in = 1'b0;
      #1;
      check($sformatf("t1_access_%0d", i), PW'(access_out), PW'(4'b0001 << i));
      check($sformatf("t1_payload_%0d", i), chan_pkt(i), make_pkt(i, 32'hA0 + i));
    end
    tick();
    check("t1_drained", PW'(access_out), PW'(4'b0000));

    // Fill stalled channel 2, fifth packet waits, then accepted on first pop.
    wait_in = 4'b0100;
    for (int j = 1; j <= 4; j++) begin
      drive(2, 32'(j));
      check($sformatf("t2_wait_fill_%0d", j), PW'(wait_out), PW'(1'b0));
      tick();
    end
    drive(2, 32'd5);
    check("t2_wait_full", PW'(wait_out), PW'(1'b1));
    tick();
    check("t2_wait_hold", PW'(wait_out), PW'(1'b1));
    check("t2_head_held", chan_pkt(2), make_pkt(2, 32'd1));
    wait_in = 4'b0000;
    #1;
    check("t2_wait_popping", PW'(wait_out), PW'(1'b0));
    tick();
    access_in = 1'b0;
    for (int j = 2; j <= 5; j++) begin
      #1;
      check($sformatf("t2_valid_%0d", j), PW'(access_out[2]), PW'(1'b1));
      check($sformatf("t2_order_%0d", j), chan_pkt(2), make_pkt(2, 32'(j)));
      tick();
    end
    check("t2_drained", PW'(access_out), PW'(4'b0000));

    // Unmapped select and disabled channel both drop.
    drive(7, 32'h77);
    check("t3_wait_unmapped", PW'(wait_out), PW'(1'b0));
    tick();
    access_in = 1'b0;
    #1;
    check("t3_pulse1",  PW'(drop_pulse), PW'(1'b1));
    check("t3_count1",  PW'(drop_count), PW'(4'd1));
    check("t3_noacc1",  PW'(access_out), PW'(4'b0000));
    tick();
    check("t3_pulse1_end", PW'(drop_pulse), PW'(1'b0));
    chan_en = 4'b1101;
    drive(1, 32'h11);
    tick();
    access_in = 1'b0;
    #1;
    check("t3_pulse2", PW'(drop_pulse), PW'(1'b1));
    check("t3_count2", PW'(drop_count), PW'(4'd2));
    check("t3_noacc2", PW'(access_out), PW'(4'b0000));
    tick();
    check("t3_pulse2_end", PW'(drop_pulse), PW'(1'b0));
    chan_en = 4'hF;

    // Saturation: 2 + 20 drops saturates the 4-bit counter at 15.
    for (int j = 0; j < 20; j++) begin
      drive(9, 32'(j));
      tick();
      if (j == 9) check("t4_count_mid", PW'(drop_count), PW'(4'd12));
    end
    access_in = 1'b0;
    #1;
    check("t4_count_sat", PW'(drop_count), PW'(4'd15));
    check("t4_pulse_last", PW'(drop_pulse), PW'(1'b1));
    tick();

    // Head-of-line blocking behind a full, stalled channel 1.
    wait_in = 4'b0010;
    for (int j = 1; j <= 4; j++) begin
      drive(1, 32'h10 + j);
      tick();
    end
    drive(1, 32'h15);
    check("t5_wait_full", PW'(wait_out), PW'(1'b1));
    tick();
    tick();
    check("t5_still_wait", PW'(wait_out), PW'(1'b1));
    check("t5_ch3_idle", PW'(access_out[3]), PW'(1'b0));
    wait_in = 4'b0000;
    #1;
    check("t5_wait_release", PW'(wait_out), PW'(1'b0));
    tick();
    drive(3, 32'h33);
    check("t5_wait_ch3", PW'(wait_out), PW'(1'b0));
    tick();
    access_in = 1'b0;
    #1;
    check("t5_ch3_valid", PW'(access_out[3]), PW'(1'b1));
    check("t5_ch3_payload", chan_pkt(3), make_pkt(3, 32'h33));
    check("t5_ch1_head", chan_pkt(1), make_pkt(1, 32'h13));
    for (int j = 0; j < 4; j++) tick();
    check("t5_drained", PW'(access_out), PW'(4'b0000));

    // Reset mid-stream discards buffered packets.
    wait_in = 4'b1001;
    drive(0, 32'hC0);
    tick();
    drive(3, 32'hC3);
    tick();
    drive(0, 32'hC1);
    tick();
    access_in = 1'b0;
    #1;
    check("t6_pre_reset", PW'(access_out), PW'(4'b1001));
    nreset = 1'b0;
    #1;
    check("t6_reset_access", PW'(access_out), PW'(4'b0000));
    check("t6_reset_wait",   PW'(wait_out),   PW'(1'b0));
    check("t6_reset_count",  PW'(drop_count), PW'(4'd0));
    wait_in = 4'b0000;
    tick();
    #2 nreset = 1'b1;
    tick();
    check("t6_no_stale", PW'(access_out), PW'(4'b0000));
    drive(3, 32'hD1);
    tick();
    access_in = 1'b0;
    #1;
    check("t6_new_valid", PW'(access_out), PW'(4'b1000));
    check("t6_new_payload", chan_pkt(3), make_pkt(3, 32'hD1));
    tick();
    check("t6_new_drained", PW'(access_out), PW'(4'b0000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
